// File: rtl/nes_pkg.sv
// Shared types and constants for the NES controller reader.
package nes_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    LOW,
    HIGH,
    DONE
  } nes_state_e;

  localparam int NUM_BUTTONS = 8;

  // Bit positions in the button vector, in controller shift order
  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  // 12 us latch and 6 us half-periods at a 25.175 MHz pixel clock
  localparam int DEF_LATCH_CYCLES = 300;
  localparam int DEF_HALF_CYCLES  = 150;
  localparam int DEF_CNT_W        = 9;

endpackage

// File: rtl/nes_sync.sv
// Two-flop synchronizer for the controller data line; resets to 1, the idle level.
module nes_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/nes_controller_reader.sv
// Polls one NES controller over latch/clock/data and presents a registered active-high button vector.
// Optional macro NES_DUAL_READ_EN: two back-to-back reads per poll, published only when they agree.
module nes_controller_reader
  import nes_pkg::*;
#(
  parameter int LATCH_CYCLES = DEF_LATCH_CYCLES,
  parameter int HALF_CYCLES  = DEF_HALF_CYCLES,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   poll,
  input  logic                   nes_data,
  output logic                   nes_latch,
  output logic                   nes_clk,
  output logic [NUM_BUTTONS-1:0] buttons,
  output logic                   valid,
  output logic                   busy
);

  localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(LATCH_CYCLES - 1);
  localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(HALF_CYCLES - 1);
  localparam logic [2:0]       LAST_IDX   = 3'(NUM_BUTTONS - 1);

  nes_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [2:0]             idx_q, idx_d;
  logic [NUM_BUTTONS-1:0] shift_q, shift_d;
  logic [NUM_BUTTONS-1:0] buttons_q, buttons_d;
  logic                   valid_q, valid_d;
  logic                   busy_q, busy_d;
  logic                   latch_q, latch_d;
  logic                   nclk_q, nclk_d;
  logic [NUM_BUTTONS-1:0] shift_sampled;
  logic                   data_sync;

`ifdef NES_DUAL_READ_EN
  logic                   second_q, second_d;
  logic [NUM_BUTTONS-1:0] first_q, first_d;
`endif

  nes_sync u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (nes_data),
    .q    (data_sync)
  );

  always_comb begin
    shift_sampled        = shift_q;
    shift_sampled[idx_q] = data_sync;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    idx_d     = idx_q;
    shift_d   = shift_q;
    buttons_d = buttons_q;
    valid_d   = 1'b0;
    busy_d    = busy_q;
    latch_d   = latch_q;
    nclk_d    = nclk_q;
`ifdef NES_DUAL_READ_EN
    second_d  = second_q;
    first_d   = first_q;
`endif

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (poll) begin
          state_d = LATCH;
          latch_d = 1'b1;
          busy_d  = 1'b1;
`ifdef NES_DUAL_READ_EN
          second_d = 1'b0;
`endif
        end
      end

      // Button A is already on the data line while the latch is high
      LATCH: begin
        if (cnt_q == LATCH_LAST) begin
          shift_d[0] = data_sync;
          cnt_d      = '0;
          idx_d      = 3'd1;
          latch_d    = 1'b0;
          state_d    = LOW;
        end
      end

      LOW: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          nclk_d  = 1'b1;
          state_d = HIGH;
        end
      end

      HIGH: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          nclk_d  = 1'b0;
          shift_d = shift_sampled;
          idx_d   = idx_q + 3'd1;
          if (idx_q == LAST_IDX) begin
`ifdef NES_DUAL_READ_EN
            if (!second_q) begin
              first_d  = shift_sampled;
              second_d = 1'b1;
              latch_d  = 1'b1;
              state_d  = LATCH;
            end else begin
              if (shift_sampled == first_q) begin
                buttons_d = ~shift_sampled;
                valid_d   = 1'b1;
              end
              state_d = DONE;
            end
`else
            buttons_d = ~shift_sampled;
            valid_d   = 1'b1;
            state_d   = DONE;
`endif
          end else begin
            state_d = LOW;
          end
        end
      end

      DONE: begin
        cnt_d   = '0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      buttons_q <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      latch_q   <= 1'b0;
      nclk_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      buttons_q <= buttons_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      latch_q   <= latch_d;
      nclk_q    <= nclk_d;
    end
  end

`ifdef NES_DUAL_READ_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      second_q <= 1'b0;
      first_q  <= '0;
    end else begin
      second_q <= second_d;
      first_q  <= first_d;
    end
  end
`endif

  assign nes_latch = latch_q;
  assign nes_clk   = nclk_q;
  assign buttons   = buttons_q;
  assign valid     = valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_nes_controller_reader.sv
// Self-checking bench for nes_controller_reader with a behavioural controller model and random pads.
module tb_nes_controller_reader;

  localparam int L_CYC = 4;
  localparam int H_CYC = 2;
  localparam int READ_LEN = L_CYC + 14 * H_CYC;

  logic       clk;
  logic       rst_n;
  logic       poll;
  logic       nes_data;
  logic       nes_latch;
  logic       nes_clk;
  logic [7:0] buttons;
  logic       valid;
  logic       busy;

  nes_controller_reader #(
    .LATCH_CYCLES(L_CYC),
    .HALF_CYCLES (H_CYC),
    .CNT_W       (9)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .poll     (poll),
    .nes_data (nes_data),
    .nes_latch(nes_latch),
    .nes_clk  (nes_clk),
    .buttons  (buttons),
    .valid    (valid),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Controller model: pads are active-high pressed, the wire is active-low.
  // Each bit is presented from the falling edge before the clock pulse that
  // would shift it, so the synchronizer latency fits inside short test phases.
  logic [7:0] pad_a = 8'h00;
  logic [7:0] pad_b = 8'h00;
  logic       disc = 1'b0;
  int         model_loads = 0;
  int         bit_pos = 8;
  logic       md_prev_latch = 1'b0;
  logic       md_prev_nclk = 1'b0;
  logic [7:0] active_pad;

  always @(posedge clk) begin
    #1;
    if (nes_latch && !md_prev_latch) begin
      model_loads++;
      bit_pos = 0;
    end else if ((md_prev_latch && !nes_latch) || (md_prev_nclk && !nes_clk)) begin
      bit_pos++;
    end
    md_prev_latch = nes_latch;
    md_prev_nclk  = nes_clk;
    active_pad = (model_loads <= 1) ? pad_a : pad_b;
    if (disc || bit_pos >= 8) nes_data = 1'b1;
    else nes_data = ~active_pad[bit_pos];
  end

  // Protocol monitor, sampled 2 time units after each rising clk edge
  int         cycle = 0;
  int         latch_rises, latch_high, clk_rises, clk_high;
  int         valid_count, valid_cycle, latch_cycle, busy_cycles, spurious;
  logic       m_prev_latch = 1'b0;
  logic       m_prev_nclk = 1'b0;
  logic [7:0] m_prev_buttons = 8'h00;

  always @(posedge clk) begin
    #2;
    cycle++;
    if (rst_n) begin
      if (nes_latch && !m_prev_latch) begin
        latch_rises++;
        if (latch_rises == 1) latch_cycle = cycle;
      end
      if (nes_latch) latch_high++;
      if (nes_clk && !m_prev_nclk) clk_rises++;
      if (nes_clk) clk_high++;
      if (valid) begin
        valid_count++;
        if (valid_count == 1) valid_cycle = cycle;
      end
      if (busy) busy_cycles++;
      if (buttons != m_prev_buttons && !valid) spurious++;
    end
    m_prev_latch   = nes_latch;
    m_prev_nclk    = nes_clk;
    m_prev_buttons = buttons;
  end

  logic [7:0] exp_buttons = 8'h00;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clearMonitor();
    @(posedge clk);
    latch_rises = 0; latch_high = 0; clk_rises = 0; clk_high = 0;
    valid_count = 0; valid_cycle = 0; latch_cycle = 0; busy_cycles = 0;
    spurious = 0; model_loads = 0;
  endtask

  task automatic checkResetOutputs(input string name);
    checkOutput($sformatf("%s.latch", name), nes_latch, 1'b0);
    checkOutput($sformatf("%s.nclk", name), nes_clk, 1'b0);
    checkOutput($sformatf("%s.busy", name), busy, 1'b0);
    checkOutput($sformatf("%s.valid", name), valid, 1'b0);
    checkOutput($sformatf("%s.buttons", name), buttons, 8'h00);
  endtask

  // One poll: drive pads, run the read, compare against the reference rules
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic dsc,
                               input logic retrig, input string name);
    logic [7:0] a_eff, b_eff;
    logic       agree;
    int         reads, n, exp_valids;
    logic       done;
    a_eff = dsc ? 8'h00 : a;
    b_eff = dsc ? 8'h00 : b;
`ifdef NES_DUAL_READ_EN
    reads = 2;
    agree = (a_eff == b_eff);
`else
    reads = 1;
    agree = 1'b1;
`endif
    if (agree) exp_buttons = a_eff;
    exp_valids = agree ? 1 : 0;

    clearMonitor();
    pad_a = a; pad_b = b; disc = dsc;
    @(negedge clk); poll = 1'b1;
    @(negedge clk); poll = 1'b0;
    n = 0; done = 1'b0;
    while (!done && n < 400) begin
      @(negedge clk);
      n++;
      poll = 1'b0;
      if (retrig && n == 5) poll = 1'b1;
      if (retrig && valid) poll = 1'b1;
      if (!busy) done = 1'b1;
    end
    poll = 1'b0;
    checkOutput($sformatf("%s.finished", name), done, 1'b1);
    repeat (retrig ? 80 : 6) @(negedge clk);

    checkOutput($sformatf("%s.buttons", name), buttons, exp_buttons);
    checkOutput($sformatf("%s.valid_count", name), valid_count, exp_valids);
    checkOutput($sformatf("%s.latch_pulses", name), latch_rises, reads);
    checkOutput($sformatf("%s.latch_cycles", name), latch_high, reads * L_CYC);
    checkOutput($sformatf("%s.clk_pulses", name), clk_rises, reads * 7);
    checkOutput($sformatf("%s.clk_high_cycles", name), clk_high, reads * 7 * H_CYC);
    checkOutput($sformatf("%s.busy_cycles", name), busy_cycles, reads * READ_LEN + 1);
    checkOutput($sformatf("%s.buttons_stable", name), spurious, 0);
    checkOutput($sformatf("%s.idle", name), busy, 1'b0);
    if (exp_valids == 1)
      checkOutput($sformatf("%s.valid_latency", name), valid_cycle - latch_cycle, reads * READ_LEN);
  endtask

  task automatic midReadReset();
    int   n;
    logic hit;
    clearMonitor();
    pad_a = 8'hC3; pad_b = 8'hC3; disc = 1'b0;
    @(negedge clk); poll = 1'b1;
    @(negedge clk); poll = 1'b0;
    n = 0; hit = 1'b0;
    while (!hit && n < 200) begin
      @(negedge clk);
      n++;
      if (clk_rises == 3 && nes_clk) hit = 1'b1;
    end
    checkOutput("midreset.reached_pulse3", hit, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    checkResetOutputs("midreset");
    rst_n = 1'b1;
    exp_buttons = 8'h00;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [7:0] ra, rb;
    poll = 1'b0;
    rst_n = 1'b0;
    nes_data = 1'b1;
    repeat (3) @(negedge clk);
    checkResetOutputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    applyStimulus(8'h09, 8'h09, 1'b0, 1'b0, "a_start");
    applyStimulus(8'h5C, 8'h5C, 1'b1, 1'b0, "disconnected");
    applyStimulus(8'hF0, 8'hF0, 1'b0, 1'b0, "pattern_f0");
    applyStimulus(8'h00, 8'h00, 1'b0, 1'b0, "released");
    applyStimulus(8'h5A, 8'h5A, 1'b0, 1'b1, "repoll");
    applyStimulus(8'h33, 8'h3C, 1'b0, 1'b0, "unstable");
    midReadReset();
    applyStimulus(8'h81, 8'h81, 1'b0, 1'b0, "after_reset");

    for (int i = 0; i < 8; i++) begin
      ra = 8'($urandom);
      rb = ($urandom_range(0, 1) == 1) ? ra : (ra ^ 8'(1 << $urandom_range(0, 7)));
      repeat ($urandom_range(0, 5)) @(negedge clk);
      applyStimulus(ra, rb, 1'b0, 1'b0, $sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
